// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: single-pattern scan-test sequencer.
// Each run shifts a pattern into the chain, pulses one functional capture,
// then shifts the chain out and counts bits that differ from the expected
// response.
// Optional macro SCAN_MASK_EN adds a per-bit compare mask input.
module scan_test_ctrl #(
    parameter int   CHAIN_LEN = 8,
    parameter int   CNT_W     = $clog2(CHAIN_LEN + 1),
    parameter logic FILL      = 1'b0
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
`ifdef SCAN_MASK_EN
    input  logic [CHAIN_LEN-1:0] mask,
`endif
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [CHAIN_LEN-1:0] response
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] MAX_MISS = CNT_W'(CHAIN_LEN);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;

    // Working copies: each is consumed from its MSB and shifted left every
    // cycle of the phase that uses it.
    logic [CHAIN_LEN-1:0] pat_sr;
    logic [CHAIN_LEN-1:0] exp_sr;
    logic [CHAIN_LEN-1:0] mask_sr;

    logic                 accept;
    logic                 shift_pat;
    logic                 sample;
    logic                 se_nxt, si_nxt, busy_nxt, done_nxt;
    logic                 miss;
    logic [CNT_W-1:0]     mis_after;

    // State and bit-counter register.
    always_ff @(posedge C) begin
        if (R) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state plus the values SE/SI/busy/done must show in the next cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        shift_pat = 1'b0;
        sample    = 1'b0;
        se_nxt    = 1'b0;
        si_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SHIFT_IN;
                    cnt_nxt   = '0;
                    se_nxt    = 1'b1;
                    si_nxt    = pattern[CHAIN_LEN-1];
                    busy_nxt  = 1'b1;
                end
            end
            S_SHIFT_IN: begin
                busy_nxt = 1'b1;
                if (cnt == LAST_BIT) begin
                    state_nxt = S_CAPTURE;
                    se_nxt    = 1'b0;
                    si_nxt    = FILL;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    shift_pat = 1'b1;
                    se_nxt    = 1'b1;
                    si_nxt    = pat_sr[CHAIN_LEN-1];
                end
            end
            S_CAPTURE: begin
                state_nxt = S_SHIFT_OUT;
                cnt_nxt   = '0;
                busy_nxt  = 1'b1;
                se_nxt    = 1'b1;
                si_nxt    = FILL;
            end
            S_SHIFT_OUT: begin
                sample = 1'b1;
                if (cnt == LAST_BIT) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    busy_nxt = 1'b1;
                    se_nxt   = 1'b1;
                    si_nxt   = FILL;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Compare of the bit currently on SO, with a saturating running count.
    always_comb begin
        miss      = sample && (SO != exp_sr[CHAIN_LEN-1]) && !mask_sr[CHAIN_LEN-1];
        mis_after = mismatch_cnt;
        if (miss && (mismatch_cnt != MAX_MISS)) begin
            mis_after = mismatch_cnt + 1'b1;
        end
    end

    // Registered chain controls, status flags and the unload/compare datapath.
    always_ff @(posedge C) begin
        if (R) begin
            SE           <= 1'b0;
            SI           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            response     <= '0;
            pat_sr       <= '0;
            exp_sr       <= '0;
            mask_sr      <= '0;
        end else begin
            SE   <= se_nxt;
            SI   <= si_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
            if (accept) begin
                pat_sr       <= pattern << 1;
                exp_sr       <= expected;
`ifdef SCAN_MASK_EN
                mask_sr      <= mask;
`else
                mask_sr      <= '0;
`endif
                mismatch_cnt <= '0;
                response     <= '0;
                pass         <= 1'b0;
            end else begin
                if (shift_pat) begin
                    pat_sr <= pat_sr << 1;
                end
                if (sample) begin
                    response     <= {response[CHAIN_LEN-2:0], SO};
                    exp_sr       <= exp_sr << 1;
                    mask_sr      <= mask_sr << 1;
                    mismatch_cnt <= mis_after;
                end
                if (done_nxt) begin
                    pass <= (mis_after == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl: drives scan_test_ctrl against an 8-cell chain whose
// functional D input is ~Q, and checks every run against a simple model:
// response = ~pattern, mismatches = popcount of unmasked differing bits.
module tb_scan_test_ctrl;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          C = 1'b0;
    logic          R;
    logic          start;
    logic [N-1:0]  pattern;
    logic [N-1:0]  expected;
    logic [N-1:0]  mask;
    logic          SO;
    logic          SE;
    logic          SI;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] mismatch_cnt;
    logic [N-1:0]  response;
    logic [N-1:0]  cells = '0;

    int num_checks = 0;
    int num_fails  = 0;

    scan_test_ctrl #(.CHAIN_LEN(N)) dut (
        .C            (C),
        .R            (R),
        .start        (start),
        .pattern      (pattern),
        .expected     (expected),
`ifdef SCAN_MASK_EN
        .mask         (mask),
`endif
        .SO           (SO),
        .SE           (SE),
        .SI           (SI),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_cnt (mismatch_cnt),
        .response     (response)
    );

    // Clock.
    always #5 C = ~C;

    // Scan chain: shift toward the last cell when SE=1, otherwise load D=~Q.
    always @(posedge C) begin
        if (SE) cells <= {cells[N-2:0], SI};
        else    cells <= ~cells;
    end
    assign SO = cells[N-1];

    // Global time limit.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int modelMismatch(input logic [N-1:0] pat, input logic [N-1:0] exp,
                                         input logic [N-1:0] msk);
        logic [N-1:0] diff;
        int           n;
        diff = (~pat) ^ exp;
`ifdef SCAN_MASK_EN
        diff = diff & ~msk;
`else
        diff = diff & ~(msk & 8'h00);
`endif
        n = $countones(diff);
        return (n > N) ? N : n;
    endfunction

    // One complete run from IDLE, checking timing, SI/SE waveform and results.
    task automatic applyStimulus(input logic [N-1:0] pat, input logic [N-1:0] exp,
                                 input logic [N-1:0] msk);
        logic [N-1:0] si_seen;
        int           bc;
        int           m_mis;
        m_mis    = modelMismatch(pat, exp, msk);
        pattern  = pat;
        expected = exp;
        mask     = msk;
        start    = 1'b1;
        @(posedge C); #1;
        start    = 1'b0;
        pattern  = N'($urandom);
        expected = N'($urandom);
        mask     = N'($urandom);
        si_seen  = '0;
        bc       = 0;
        while (busy === 1'b1 && bc < 60) begin
            if (bc < N) si_seen[N-1-bc] = SI;
            else        checkOutput("si_fill", {31'd0, SI}, 32'd0);
            checkOutput("se_run", {31'd0, SE}, (bc == N) ? 32'd0 : 32'd1);
            checkOutput("done_early", {31'd0, done}, 32'd0);
            bc++;
            @(posedge C); #1;
        end
        checkOutput("busy_len", bc, 2 * N + 1);
        checkOutput("si_seq", {24'd0, si_seen}, {24'd0, pat});
        checkOutput("done", {31'd0, done}, 32'd1);
        checkOutput("se_done", {31'd0, SE}, 32'd0);
        checkOutput("response", {24'd0, response}, {24'd0, ~pat});
        checkOutput("mismatch_cnt", {28'd0, mismatch_cnt}, m_mis);
        checkOutput("pass", {31'd0, pass}, (m_mis == 0) ? 32'd1 : 32'd0);
        @(posedge C); #1;
        checkOutput("done_pulse", {31'd0, done}, 32'd0);
        checkOutput("busy_idle", {31'd0, busy}, 32'd0);
        checkOutput("pass_held", {31'd0, pass}, (m_mis == 0) ? 32'd1 : 32'd0);
        checkOutput("mismatch_held", {28'd0, mismatch_cnt}, m_mis);
    endtask

    initial begin
        logic [N-1:0] rp, re, rm;
        int           gap;
        R        = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        expected = '0;
        mask     = '0;
        repeat (3) @(posedge C);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_SE", {31'd0, SE}, 32'd0);
        checkOutput("rst_SI", {31'd0, SI}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_pass", {31'd0, pass}, 32'd0);
        checkOutput("rst_mismatch", {28'd0, mismatch_cnt}, 32'd0);
        checkOutput("rst_response", {24'd0, response}, 32'd0);
        R = 1'b0;
        @(posedge C); #1;

        $display("[TB] directed runs");
        applyStimulus(8'hA5, 8'h5A, 8'h00);
        applyStimulus(8'hA5, 8'h5B, 8'h00);
        applyStimulus(8'h00, 8'h00, 8'h00);
        applyStimulus(8'hA5, 8'h5B, 8'h01);

        $display("[TB] reset during shift-in");
        pattern  = 8'hA5;
        expected = 8'h5A;
        start    = 1'b1;
        @(posedge C); #1;
        start = 1'b0;
        repeat (3) @(posedge C);
        #1;
        R = 1'b1;
        @(posedge C); #1;
        R = 1'b0;
        checkOutput("abort_SE", {31'd0, SE}, 32'd0);
        checkOutput("abort_SI", {31'd0, SI}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_response", {24'd0, response}, 32'd0);
        @(posedge C); #1;
        checkOutput("abort_stay_idle", {31'd0, busy}, 32'd0);
        applyStimulus(8'hA5, 8'h5A, 8'h00);

        $display("[TB] start held high");
        pattern  = 8'hA5;
        expected = 8'h5A;
        mask     = 8'h00;
        start    = 1'b1;
        gap      = 0;
        while (done !== 1'b1 && gap < 100) begin
            @(posedge C); #1;
            gap++;
        end
        checkOutput("held_first_done", gap, 2 * N + 2);
        for (int i = 0; i < 2; i++) begin
            gap = 0;
            do begin
                @(posedge C); #1;
                gap++;
            end while (done !== 1'b1 && gap < 100);
            checkOutput("held_done_period", gap, 2 * N + 3);
            checkOutput("held_response", {24'd0, response}, 32'h5A);
        end
        start = 1'b0;
        repeat (3) @(posedge C);
        #1;
        checkOutput("held_release_idle", {31'd0, busy}, 32'd0);

        $display("[TB] random runs");
        for (int i = 0; i < 10; i++) begin
            rp = N'($urandom);
            re = (~rp) ^ (N'($urandom) & N'($urandom) & N'($urandom));
            rm = N'($urandom) & N'($urandom);
            if (i == 3) re = rp;
            applyStimulus(rp, re, rm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
